dm_responder: RTL and testbench

DM_RESPONDER -- requirements
Module: dm_responder

---
 rtl/dm_responder_pkg.sv | 40 ++++
 rtl/dm_lane_ext.sv | 34 +++
 rtl/dm_responder.sv | 125 ++++++++++++
 tb/tb_dm_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_responder_pkg.sv
// +----------------------------------------------------------------------------+
// | dm_responder_pkg : shared access-type and FSM encodings, lane helpers        |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

package dm_responder_pkg;

  localparam logic [2:0] TYPE_W  = 3'b000;
  localparam logic [2:0] TYPE_HU = 3'b001;
  localparam logic [2:0] TYPE_H  = 3'b010;
  localparam logic [2:0] TYPE_BU = 3'b011;
  localparam logic [2:0] TYPE_B  = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic [3:0] lane_enables(input logic [2:0] acc_type, input logic [1:0] offset);
    case (acc_type)
      TYPE_W:          lane_enables = 4'b1111;
      TYPE_HU, TYPE_H: lane_enables = offset[1] ? 4'b1100 : 4'b0011;
      TYPE_BU, TYPE_B: lane_enables = 4'b0001 << offset;
      default:         lane_enables = 4'b0000;
    endcase
  endfunction

  // Alignment and type legality only; range depends on the array depth.
  function automatic logic access_fault(input logic [2:0] acc_type, input logic [1:0] offset);
    case (acc_type)
      TYPE_W:          access_fault = (offset != 2'b00);
      TYPE_HU, TYPE_H: access_fault = offset[0];
      TYPE_BU, TYPE_B: access_fault = 1'b0;
      default:         access_fault = 1'b1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dm_lane_ext.sv
// +----------------------------------------------------------------------------+
// | dm_lane_ext : byte/half lane select with zero or sign extension              |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module dm_lane_ext
  import dm_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  req_type,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  lane_byte;

  always_comb begin
    half      = offset[1] ? word[31:16] : word[15:0];
    lane_byte = word[{offset, 3'b000} +: 8];
    case (req_type)
      TYPE_W:  data = word;
      TYPE_HU: data = {16'h0000, half};
      TYPE_H:  data = {{16{half[15]}}, half};
      TYPE_BU: data = {24'h000000, lane_byte};
      TYPE_B:  data = {{24{lane_byte[7]}}, lane_byte};
      default: data = 32'h0000_0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_responder.sv
// +----------------------------------------------------------------------------+
// | dm_responder : fixed-latency data-memory responder for the M stage           |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH_WORDS];
  logic          accept;
  logic          out_of_range;
  logic          fault;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wr_lanes;
  logic [31:0]   rd_word;
  logic [31:0]   ext_data;
  logic [31:0]   rdata_q;
  logic          err_q;

  assign accept       = (state == ST_IDLE) && req_valid;
  assign idx          = req_addr[AW+1:2];
  assign out_of_range = {2'b00, req_addr[31:2]} >= DEPTH_WORDS;
  assign fault        = access_fault(req_type, req_addr[1:0]) | out_of_range;
  assign wr_en        = accept && req_write && !fault;
  assign be           = lane_enables(req_type, req_addr[1:0]);
  assign rd_word      = mem[idx];

  always_comb begin
    case (req_type)
      TYPE_HU, TYPE_H: wr_lanes = {2{req_wdata[15:0]}};
      TYPE_BU, TYPE_B: wr_lanes = {4{req_wdata[7:0]}};
      default:         wr_lanes = req_wdata;
    endcase
  end

  dm_lane_ext u_lane_ext (
    .word     (rd_word),
    .req_type (req_type),
    .offset   (req_addr[1:0]),
    .data     (ext_data)
  );

  // Loads and stores both resolve at acceptance; only the result is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < DEPTH_WORDS; w++) mem[w] <= 32'h0000_0000;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wr_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (req_write || fault) ? 32'h0000_0000 : ext_data;
      err_q   <= fault;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= CNT_LOAD;
    end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_valid) state_next = (LATENCY > 1) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt == 4'd0) state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    rsp_valid = (state == ST_RESP);
    rsp_rdata = rsp_valid ? rdata_q : 32'h0000_0000;
    rsp_err   = rsp_valid && err_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// +----------------------------------------------------------------------------+
// | tb_dm_responder : directed table, corner sequences and random accesses       |
// | Revision 1.0                                                                 |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dm_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_type = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mdl [4*DEPTH];

  typedef struct {
    logic        wr;
    logic [2:0]  ty;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl[$];

  dm_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mdl[i]) mdl[i] = 8'h00;
  endtask

  // Byte-addressed little-endian memory with the access rules applied directly.
  task automatic model_access(input logic wr, input logic [2:0] ty, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    n  = (ty == 3'd0) ? 4 : ((ty == 3'd1 || ty == 3'd2) ? 2 : 1);
    er = (ty > 3'd4) || ((a % n) != 0) || ((a / 4) >= DEPTH);
    rd = 32'h0;
    if (!er) begin
      if (wr) begin
        for (int k = 0; k < n; k++) mdl[a + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = mdl[a + k];
        if (ty == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
        if (ty == 3'd4 && v[7])  v = v | 32'hFFFF_FF00;
        rd = v;
      end
    end
  endtask

  // One access from an idle responder; inputs are scrambled right after acceptance.
  task automatic access(input logic wr, input logic [2:0] ty, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat);
    int guard = 0;
    logic busy_ok;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b1; req_write = wr; req_type = ty; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_type = 3'($urandom);
    req_addr  = $urandom; req_wdata = $urandom;
    lat = 1;
    busy_ok = busy;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      busy_ok = busy_ok & busy;
    end
    rd = rsp_rdata;
    er = rsp_err;
    check("busy_during_access", busy_ok, 1);
    @(negedge clk);
    check("rsp_single_pulse", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd;
    logic er, exp_er;
    int lat;
    int accepts[$];
    int rsp_cnt;
    logic wr;
    logic [2:0] ty;
    logic [31:0] a, wd;
    int r;

    // Reset state
    #2;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_req_ready", req_ready, 1);
    check("reset_rsp_rdata", rsp_rdata, 0);
    check("reset_rsp_err", rsp_err, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_clear();
    @(negedge clk);

    tbl.push_back('{1'b1, 3'd0, 32'h10,   32'h1234_5678, 32'h0,          1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h10,   32'h0,         32'h1234_5678,  1'b0});
    tbl.push_back('{1'b1, 3'd4, 32'h13,   32'h0000_0080, 32'h0,          1'b0});
    tbl.push_back('{1'b0, 3'd4, 32'h13,   32'h0,         32'hFFFF_FF80,  1'b0});
    tbl.push_back('{1'b0, 3'd3, 32'h13,   32'h0,         32'h0000_0080,  1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'h10,   32'h0,         32'h8034_5678,  1'b0});
    tbl.push_back('{1'b1, 3'd1, 32'h22,   32'h0000_BEEF, 32'h0,          1'b0});
    tbl.push_back('{1'b0, 3'd2, 32'h22,   32'h0,         32'hFFFF_BEEF,  1'b0});
    tbl.push_back('{1'b0, 3'd1, 32'h20,   32'h0,         32'h0000_0000,  1'b0});
    tbl.push_back('{1'b1, 3'd0, 32'h11,   32'hDEAD_BEEF, 32'h0,          1'b1});
    tbl.push_back('{1'b0, 3'd0, 32'h1000, 32'h0,         32'h0,          1'b1});
    tbl.push_back('{1'b0, 3'd0, 32'h10,   32'h0,         32'h8034_5678,  1'b0});
    tbl.push_back('{1'b0, 3'd5, 32'h10,   32'h0,         32'h0,          1'b1});
    tbl.push_back('{1'b0, 3'd2, 32'h21,   32'h0,         32'h0,          1'b1});
    tbl.push_back('{1'b1, 3'd1, 32'h23,   32'h0000_1111, 32'h0,          1'b1});
    tbl.push_back('{1'b0, 3'd1, 32'h22,   32'h0,         32'h0000_BEEF,  1'b0});
    tbl.push_back('{1'b1, 3'd3, 32'hFFF,  32'h0000_005A, 32'h0,          1'b0});
    tbl.push_back('{1'b0, 3'd3, 32'hFFF,  32'h0,         32'h0000_005A,  1'b0});
    tbl.push_back('{1'b0, 3'd0, 32'hFFC,  32'h0,         32'h5A00_0000,  1'b0});

    foreach (tbl[i]) begin
      access(tbl[i].wr, tbl[i].ty, tbl[i].addr, tbl[i].wdata, rd, er, lat);
      model_access(tbl[i].wr, tbl[i].ty, tbl[i].addr, tbl[i].wdata, exp_rd, exp_er);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
      check($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // req_valid held high: accepts every LAT+1 cycles, no queuing
    model_access(1'b0, 3'd0, 32'h10, 32'h0, exp_rd, exp_er);
    req_valid = 1'b1; req_write = 1'b0; req_type = 3'd0; req_addr = 32'h10;
    rsp_cnt = 0;
    for (int c = 0; c < 13; c++) begin
      if (req_ready) accepts.push_back(c);
      check($sformatf("hold_ready_c%0d", c), req_ready, (c % (LAT + 1)) == 0);
      check($sformatf("hold_busy_c%0d", c), busy, (c % (LAT + 1)) != 0);
      check($sformatf("hold_rsp_c%0d", c), rsp_valid, (c % (LAT + 1)) == LAT);
      if (rsp_valid) begin
        rsp_cnt++;
        check("hold_rdata", rsp_rdata, exp_rd);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("hold_accept_count", accepts.size(), 5);
    check("hold_rsp_count", rsp_cnt, 4);
    for (int k = 1; k < accepts.size(); k++)
      check("hold_accept_spacing", accepts[k] - accepts[k-1], LAT + 1);
    r = 0;
    while (!req_ready && r < 20) begin
      @(negedge clk);
      r++;
    end

    // Reset while a store is in WAIT
    req_valid = 1'b1; req_write = 1'b1; req_type = 3'd0; req_addr = 32'h40; req_wdata = 32'hAAAA_5555;
    @(negedge clk);
    req_valid = 1'b0;
    check("inflight_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    check("midreset_rsp_valid", rsp_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_ready", req_ready, 1);
    check("midreset_rdata", rsp_rdata, 0);
    #1 reset = 1'b1;
    model_clear();
    rsp_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    check("dropped_no_rsp", rsp_cnt, 0);
    access(1'b0, 3'd0, 32'h40, 32'h0, rd, er, lat);
    check("after_reset_lw40", rd, 32'h0);
    check("after_reset_lw40_err", er, 0);
    access(1'b0, 3'd0, 32'h10, 32'h0, rd, er, lat);
    check("after_reset_lw10", rd, 32'h0);

    // Random accesses against the byte-level model
    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom_range(0, 1));
      ty = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      r  = int'($urandom_range(0, 19));
      if (r == 0)      a = 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
      else if (r == 1) a = 32'(4 * DEPTH - 4) + 32'($urandom_range(0, 3));
      else             a = 32'h100 + 32'($urandom_range(0, 31));
      wd = $urandom;
      model_access(wr, ty, a, wd, exp_rd, exp_er);
      access(wr, ty, a, wd, rd, er, lat);
      check($sformatf("rand%0d_rdata", i), rd, exp_rd);
      check($sformatf("rand%0d_err", i), er, exp_er);
      check($sformatf("rand%0d_latency", i), lat, LAT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
